// File: rtl/pico_io_pkg.sv
// Shared types and address offsets for the Picoblaze port bank and its interrupt controller.
package pico_io_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  // Offsets of the interrupt registers above the last user port in each map
  localparam int PENDING_OFS = 0;
  localparam int MASK_OFS    = 1;
  localparam int CLEAR_OFS   = 1;

  localparam int MAX_N_IN   = 14;
  localparam int MAX_N_OUT  = 14;
  localparam int MAX_N_KOUT = 16;
  localparam int MAX_N_IRQ  = 8;

endpackage

// File: rtl/pico_irq_ctrl.sv
// Interrupt controller: rising-edge detect into sticky pending bits, mask gate, IDLE/ASSERT/SERVICE handshake.
// interrupt rises one cycle after pending is set; it is held until interruptAck regardless of later clears.
module pico_irq_ctrl
  import pico_io_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             irq_ack,
  input  logic             mask_wr_vld,
  input  logic             clr_vld,
  input  logic [N_IRQ-1:0] wr_dat,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             irq
);

  logic [N_IRQ-1:0] src_hist_q, src_hist_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] rise;
  irq_state_e       state_q, state_d;
  logic             irq_q, irq_d;
  logic             req;

  always_comb begin
    src_hist_d = irq_src;
    rise       = irq_src & ~src_hist_q;
    pending_d  = pending_q;
    if (clr_vld) begin
      pending_d = pending_d & ~wr_dat;
    end
    // A new edge overrides a clear of the same bit in the same cycle
    pending_d = pending_d | rise;
    mask_d    = mask_wr_vld ? wr_dat : mask_q;
  end

  always_comb begin
    req     = |(pending_q & mask_q);
    state_d = state_q;
    case (state_q)
      IRQ_IDLE:    if (req)     state_d = IRQ_ASSERT;
      IRQ_ASSERT:  if (irq_ack) state_d = IRQ_SERVICE;
      IRQ_SERVICE: if (!req)    state_d = IRQ_IDLE;
      default:                  state_d = IRQ_IDLE;
    endcase
    irq_d = (state_d == IRQ_ASSERT);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      src_hist_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      state_q    <= IRQ_IDLE;
      irq_q      <= 1'b0;
    end else begin
      src_hist_q <= src_hist_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      state_q    <= state_d;
      irq_q      <= irq_d;
    end
  end

  assign pending = pending_q;
  assign mask    = mask_q;
  assign irq     = irq_q;

endmodule

// File: rtl/pico_port_bank.sv
// Picoblaze I/O bank: decodes portId[3:0] into user input/output/constant ports plus interrupt registers.
// Read data and all strobes are registered (one-cycle latency); the bus has no backpressure.
module pico_port_bank
  import pico_io_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int N_KOUT = 1,
  parameter int N_IRQ  = 4
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [7:0]          portId,
  input  logic [7:0]          outPort,
  input  logic                readStrobe,
  input  logic                writeStrobe,
  input  logic                kWriteStrobe,
  input  logic [8*N_IN-1:0]   inData,
  input  logic [N_IRQ-1:0]    irqSrc,
  input  logic                interruptAck,
  output logic [7:0]          inPort,
  output logic [8*N_OUT-1:0]  outData,
  output logic [8*N_KOUT-1:0] kOutData,
  output logic [N_IN-1:0]     readPulse,
  output logic [N_OUT-1:0]    writePulse,
  output logic [N_KOUT-1:0]   kWritePulse,
  output logic                interrupt
);

  localparam int PEND_RD_ADDR = N_IN + PENDING_OFS;
  localparam int MASK_RD_ADDR = N_IN + MASK_OFS;
  localparam int MASK_WR_ADDR = N_OUT;
  localparam int CLR_WR_ADDR  = N_OUT + CLEAR_OFS;

  logic [3:0]          addr;
  logic                unused_port_hi;
  logic [7:0]          in_port_q, in_port_d;
  logic [8*N_OUT-1:0]  out_data_q, out_data_d;
  logic [8*N_KOUT-1:0] k_out_data_q, k_out_data_d;
  logic [N_IN-1:0]     read_pulse_q, read_pulse_d;
  logic [N_OUT-1:0]    write_pulse_q, write_pulse_d;
  logic [N_KOUT-1:0]   k_write_pulse_q, k_write_pulse_d;
  logic                mask_wr_vld, clr_vld;
  logic [N_IRQ-1:0]    irq_pending, irq_mask;

  // Only the low nibble is decoded; the upper address bits alias
  assign addr           = portId[3:0];
  assign unused_port_hi = &{1'b0, portId[7:4]};

  always_comb begin
    in_port_d    = '0;
    read_pulse_d = '0;
    for (int p = 0; p < N_IN; p++) begin
      if (int'(addr) == p) begin
        in_port_d       = inData[8*p +: 8];
        read_pulse_d[p] = readStrobe;
      end
    end
    if (int'(addr) == PEND_RD_ADDR) in_port_d = 8'(irq_pending);
    if (int'(addr) == MASK_RD_ADDR) in_port_d = 8'(irq_mask);
  end

  always_comb begin
    out_data_d    = out_data_q;
    write_pulse_d = '0;
    for (int p = 0; p < N_OUT; p++) begin
      if (writeStrobe && int'(addr) == p) begin
        out_data_d[8*p +: 8] = outPort;
        write_pulse_d[p]     = 1'b1;
      end
    end
    mask_wr_vld = writeStrobe && (int'(addr) == MASK_WR_ADDR);
    clr_vld     = writeStrobe && (int'(addr) == CLR_WR_ADDR);
  end

  always_comb begin
    k_out_data_d    = k_out_data_q;
    k_write_pulse_d = '0;
    for (int k = 0; k < N_KOUT; k++) begin
      if (kWriteStrobe && int'(addr) == k) begin
        k_out_data_d[8*k +: 8] = outPort;
        k_write_pulse_d[k]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      in_port_q       <= '0;
      out_data_q      <= '0;
      k_out_data_q    <= '0;
      read_pulse_q    <= '0;
      write_pulse_q   <= '0;
      k_write_pulse_q <= '0;
    end else begin
      in_port_q       <= in_port_d;
      out_data_q      <= out_data_d;
      k_out_data_q    <= k_out_data_d;
      read_pulse_q    <= read_pulse_d;
      write_pulse_q   <= write_pulse_d;
      k_write_pulse_q <= k_write_pulse_d;
    end
  end

  pico_irq_ctrl #(
    .N_IRQ(N_IRQ)
  ) u_irq_ctrl (
    .clk        (clk),
    .nRst       (nRst),
    .irq_src    (irqSrc),
    .irq_ack    (interruptAck),
    .mask_wr_vld(mask_wr_vld),
    .clr_vld    (clr_vld),
    .wr_dat     (outPort[N_IRQ-1:0]),
    .pending    (irq_pending),
    .mask       (irq_mask),
    .irq        (interrupt)
  );

  assign inPort      = in_port_q;
  assign outData     = out_data_q;
  assign kOutData    = k_out_data_q;
  assign readPulse   = read_pulse_q;
  assign writePulse  = write_pulse_q;
  assign kWritePulse = k_write_pulse_q;

endmodule

// File: tb/tb_pico_port_bank.sv
// Directed bench for pico_port_bank at default parameters (N_IN=2, N_OUT=2, N_KOUT=1, N_IRQ=4).
module tb_pico_port_bank;

  logic        clk;
  logic        nRst;
  logic [7:0]  portId;
  logic [7:0]  outPort;
  logic        readStrobe;
  logic        writeStrobe;
  logic        kWriteStrobe;
  logic [15:0] inData;
  logic [3:0]  irqSrc;
  logic        interruptAck;
  logic [7:0]  inPort;
  logic [15:0] outData;
  logic [7:0]  kOutData;
  logic [1:0]  readPulse;
  logic [1:0]  writePulse;
  logic [0:0]  kWritePulse;
  logic        interrupt;

  int vectors;
  int miscompares;

  pico_port_bank #(
    .N_IN(2), .N_OUT(2), .N_KOUT(1), .N_IRQ(4)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .portId      (portId),
    .outPort     (outPort),
    .readStrobe  (readStrobe),
    .writeStrobe (writeStrobe),
    .kWriteStrobe(kWriteStrobe),
    .inData      (inData),
    .irqSrc      (irqSrc),
    .interruptAck(interruptAck),
    .inPort      (inPort),
    .outData     (outData),
    .kOutData    (kOutData),
    .readPulse   (readPulse),
    .writePulse  (writePulse),
    .kWritePulse (kWritePulse),
    .interrupt   (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    nRst         = 1'b1;
    portId       = 8'h00;
    outPort      = 8'h00;
    readStrobe   = 1'b0;
    writeStrobe  = 1'b0;
    kWriteStrobe = 1'b0;
    inData       = 16'h0000;
    irqSrc       = 4'h0;
    interruptAck = 1'b0;
    #1 nRst = 1'b0;
    #2;
    check("rst_inport", inPort, 8'h00);
    check("rst_outdata", outData, 16'h0000);
    check("rst_koutdata", kOutData, 8'h00);
    check("rst_pulses", {readPulse, writePulse, kWritePulse}, 5'b0);
    check("rst_irq", interrupt, 1'b0);
    @(negedge clk);
    nRst = 1'b1;
    tick();

    // User output write to port 1
    writeStrobe = 1'b1; portId = 8'h01; outPort = 8'hA5;
    tick();
    writeStrobe = 1'b0;
    check("wr1_data", outData, 16'hA500);
    check("wr1_pulse", writePulse, 2'b10);
    tick();
    check("wr1_pulse_end", writePulse, 2'b00);
    check("wr1_hold", outData, 16'hA500);
    writeStrobe = 1'b1; portId = 8'h00; outPort = 8'h5A;
    tick();
    writeStrobe = 1'b0;
    check("wr0_data", outData, 16'hA55A);
    check("wr0_pulse", writePulse, 2'b01);
    check("wr_no_kout", kOutData, 8'h00);

    // Constant-output port writes
    kWriteStrobe = 1'b1; portId = 8'h00; outPort = 8'h77;
    tick();
    check("kwr_data", kOutData, 8'h77);
    check("kwr_pulse", kWritePulse, 1'b1);
    check("kwr_no_out", outData, 16'hA55A);
    portId = 8'h01; outPort = 8'h99;
    tick();
    kWriteStrobe = 1'b0;
    check("kwr_oor_data", kOutData, 8'h77);
    check("kwr_oor_pulse", kWritePulse, 1'b0);

    // Input reads
    inData = 16'h3C11; portId = 8'h01; readStrobe = 1'b1;
    tick();
    readStrobe = 1'b0;
    check("rd1_data", inPort, 8'h3C);
    check("rd1_pulse", readPulse, 2'b10);
    tick();
    check("rd1_pulse_end", readPulse, 2'b00);
    check("rd1_nostrobe", inPort, 8'h3C);
    portId = 8'h00;
    tick();
    check("rd0_data", inPort, 8'h11);
    portId = 8'h0F;
    tick();
    check("rd_unmapped", inPort, 8'h00);
    portId = 8'h11;
    tick();
    check("rd_alias", inPort, 8'h3C);

    // Masked-in source 0: assert, hold until ack, then clear
    writeStrobe = 1'b1; portId = 8'h02; outPort = 8'h01;
    tick();
    writeStrobe = 1'b0; portId = 8'h03;
    tick();
    check("mask_rb", inPort, 8'h01);
    irqSrc = 4'b0001; portId = 8'h02;
    tick();
    check("irq0_not_yet", interrupt, 1'b0);
    check("pend0_pre", inPort, 8'h00);
    tick();
    check("irq0_asserted", interrupt, 1'b1);
    check("pend0_rb", inPort, 8'h01);
    tick();
    tick();
    check("irq0_hold", interrupt, 1'b1);
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    check("irq0_acked", interrupt, 1'b0);
    tick();
    check("irq0_service", interrupt, 1'b0);
    writeStrobe = 1'b1; portId = 8'h03; outPort = 8'h01;
    tick();
    writeStrobe = 1'b0; portId = 8'h02;
    tick();
    check("pend0_cleared", inPort, 8'h00);
    check("irq0_idle", interrupt, 1'b0);

    // Masked-out source 2 still latches pending
    writeStrobe = 1'b1; portId = 8'h02; outPort = 8'h00;
    tick();
    writeStrobe = 1'b0;
    irqSrc = 4'b0101; portId = 8'h02;
    tick();
    tick();
    check("pend2_masked", inPort, 8'h04);
    check("irq2_masked", interrupt, 1'b0);
    writeStrobe = 1'b1; portId = 8'h02; outPort = 8'h04;
    tick();
    writeStrobe = 1'b0;
    check("irq2_mask_edge", interrupt, 1'b0);
    tick();
    check("irq2_unmasked", interrupt, 1'b1);

    // Clearing pending while asserted does not drop the request
    writeStrobe = 1'b1; portId = 8'h03; outPort = 8'h04;
    tick();
    writeStrobe = 1'b0; portId = 8'h02;
    tick();
    check("pend2_cleared", inPort, 8'h00);
    check("irq2_stays", interrupt, 1'b1);
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    check("irq2_acked", interrupt, 1'b0);
    tick();

    // Same-cycle edge and clear on bit 1: edge wins
    irqSrc = 4'b0111; writeStrobe = 1'b1; portId = 8'h03; outPort = 8'h02;
    tick();
    writeStrobe = 1'b0; portId = 8'h02;
    tick();
    check("pend1_set_wins", inPort, 8'h02);
    check("irq1_masked", interrupt, 1'b0);

    // Reset during ASSERT
    writeStrobe = 1'b1; portId = 8'h02; outPort = 8'h01;
    tick();
    writeStrobe = 1'b0;
    irqSrc = 4'b0110;
    tick();
    irqSrc = 4'b0111;
    tick();
    tick();
    check("irq_pre_rst", interrupt, 1'b1);
    check("out_pre_rst", outData, 16'hA55A);
    #1 nRst = 1'b0;
    #1;
    check("rst_async_irq", interrupt, 1'b0);
    check("rst_async_out", outData, 16'h0000);
    check("rst_async_kout", kOutData, 8'h00);
    check("rst_async_inport", inPort, 8'h00);
    portId = 8'h03;
    @(negedge clk);
    nRst = 1'b1;
    tick();
    check("rst_mask_rb", inPort, 8'h00);
    check("rst_irq_after", interrupt, 1'b0);
    portId = 8'h02;
    tick();
    check("rst_hist_edges", inPort, 8'h07);
    tick();
    check("rst_irq_masked", interrupt, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pico_port_bank.md
PICO_PORT_BANK -- requirements
Module: pico_port_bank

Interface
REQ-001 Parameter N_IN, default 2: user input ports, 1..14.
REQ-002 Parameter N_OUT, default 2: user output ports, 1..14.
REQ-003 Parameter N_KOUT, default 1: constant-output ports, 1..16.
REQ-004 Parameter N_IRQ, default 4: interrupt sources, 1..8.
REQ-005 clk  in  1  system clock; all logic rising-edge.
REQ-006 nRst  in  1  reset, asynchronous assert, active-low.
REQ-007 portId  in  8  Picoblaze port address.
REQ-008 outPort  in  8  Picoblaze write data.
REQ-009 readStrobe / writeStrobe / kWriteStrobe  in  1 each  Picoblaze strobes.
REQ-010 inData  in  8*N_IN  user input port p at bits [8p+7:8p].
REQ-011 irqSrc  in  N_IRQ  interrupt request levels, synchronous to clk.
REQ-012 interruptAck  in  1  Picoblaze interrupt acknowledge.
REQ-013 inPort  out  8  registered read data to Picoblaze.
REQ-014 outData  out  8*N_OUT  user output registers, packed as inData.
REQ-015 kOutData  out  8*N_KOUT  constant-output registers, packed likewise.
REQ-016 readPulse / writePulse / kWritePulse  out  N_IN / N_OUT / N_KOUT  one-cycle per-port strobes.
REQ-017 interrupt  out  1  interrupt request to Picoblaze.

Function
REQ-018 Input address map on portId[3:0]: 0..N_IN-1 user ports; N_IN = IRQ pending; N_IN+1 = IRQ mask readback; all other addresses read 0x00.
REQ-019 inPort shall update every cycle from portId (one-cycle latency), independent of readStrobe; unused upper bits of pending/mask read 0.
REQ-020 readPulse[p] shall assert one cycle after a cycle with readStrobe and portId[3:0]==p.
REQ-021 Output address map on portId[3:0]: 0..N_OUT-1 user registers; N_OUT = IRQ mask; N_OUT+1 = IRQ clear (write-1-to-clear pending); other addresses ignored.
REQ-022 On writeStrobe to user address p, outData[p] shall take outPort next edge and writePulse[p] shall pulse that same edge, for one cycle.
REQ-023 kWriteStrobe shall decode portId[3:0]; address k<N_KOUT loads kOutData[k] and pulses kWritePulse[k]; writeStrobe never updates kOutData.
REQ-024 Each irqSrc bit shall be rising-edge detected against its previous-cycle value; a detected edge sets pending[i].
REQ-025 Same-cycle set-edge and clear-bit on one pending bit: set wins.
REQ-026 Mask shall gate only the request; masked sources still latch pending.
REQ-027 IRQ FSM states IDLE, ASSERT, SERVICE; interrupt high only in ASSERT.
REQ-028 IDLE->ASSERT when (pending & mask)!=0; ASSERT->SERVICE on interruptAck; SERVICE->IDLE when (pending & mask)==0; SERVICE never re-asserts interrupt.
REQ-029 If (pending & mask) becomes 0 while in ASSERT (software clear or mask), FSM shall stay in ASSERT until interruptAck.
REQ-030 interrupt shall be registered; first assertion one cycle after pending is set.

Reset
REQ-031 nRst low shall asynchronously clear inPort, outData, kOutData, all pulses, pending, mask, edge-history registers, and force IDLE (interrupt=0).
REQ-032 Edge history resets to 0: an irqSrc bit high at reset release registers an edge on the first clock.
REQ-033 Reset mid-ASSERT shall drop interrupt immediately without awaiting interruptAck.

Structure
REQ-034 Shared package pico_io_pkg: IRQ state type, address-offset constants (PENDING_OFS=0, MASK_OFS=1, CLEAR_OFS=1 relative to N_IN/N_OUT), max-parameter constants.
REQ-035 Interrupt logic (edge detect, pending, mask, FSM) in sub-module pico_irq_ctrl; port decode stays in pico_port_bank.

Verification
REQ-036 N_OUT=2: writeStrobe, portId=0x01, outPort=0xA5 -> outData[15:8]=0xA5 next edge, writePulse=2'b10 one cycle, outData[7:0] unchanged.
REQ-037 N_IN=2: inData=0x3C_11, portId=0x01 held -> inPort=0x3C after one edge; readStrobe that cycle -> readPulse=2'b10 one cycle; portId=0x0F -> inPort=0x00.
REQ-038 mask=0x01 (write 0x01 to port 2), irqSrc[0] 0->1 -> interrupt high from the edge after pending set; held until interruptAck; low after; write 0x01 to port 3 -> pending=0, FSM IDLE.
REQ-039 mask=0x00, irqSrc[2] edge -> pending=0x04 readable at port N_IN, interrupt stays 0; then mask=0x04 -> interrupt asserts.
REQ-040 Clear write to bit 1 in same cycle as irqSrc[1] edge -> pending[1]=1 afterwards.
REQ-041 nRst low during ASSERT -> interrupt=0, outData=0, mask=0 immediately, before next clk edge.
